// File: rtl/ula_pkg.sv
// Shared op codes, FSM states and helpers for the ULA_LO sequencer.
package ula_pkg;

   localparam logic [4:0] OP_SHL   = 5'b01000;
   localparam logic [4:0] OP_SAR   = 5'b01001;
   localparam logic [4:0] OP_ZERO  = 5'b10000;
   localparam logic [4:0] OP_AND   = 5'b10001;
   localparam logic [4:0] OP_PASSB = 5'b10011;
   localparam logic [4:0] OP_PASSA = 5'b10101;
   localparam logic [4:0] OP_XOR   = 5'b10110;
   localparam logic [4:0] OP_ONE   = 5'b11111;

   typedef enum logic [1:0] {
      IDLE,
      RUN,
      DONE
   } state_t;

   function automatic logic is_shift(input logic [4:0] op);
      return (op == OP_SHL) || (op == OP_SAR);
   endfunction

   function automatic logic is_valid_op(input logic [4:0] op);
      return op[4] || is_shift(op);
   endfunction

endpackage

// File: rtl/ula_lo_ctrl_if.sv
// Request/response handshake bundle between issue logic and the sequencer.
interface ula_lo_ctrl_if #(
   parameter int BITS = 8
);
   localparam int CW = $clog2(BITS + 1);

   logic            req_valid;
   logic            req_ready;
   logic [BITS-1:0] req_a;
   logic [BITS-1:0] req_b;
   logic [4:0]      req_op;
   logic [CW-1:0]   req_cnt;
   logic            clr;
   logic            rsp_valid;
   logic            rsp_ready;
   logic [BITS-1:0] rsp_resu;
   logic            rsp_c;
   logic            rsp_s;
   logic            rsp_z;
   logic            rsp_o;
   logic            rsp_err;

   modport master (
      output req_valid, req_a, req_b, req_op, req_cnt,
      output clr, rsp_ready,
      input  req_ready, rsp_valid, rsp_resu,
      input  rsp_c, rsp_s, rsp_z, rsp_o, rsp_err
   );

   modport slave (
      input  req_valid, req_a, req_b, req_op, req_cnt,
      input  clr, rsp_ready,
      output req_ready, rsp_valid, rsp_resu,
      output rsp_c, rsp_s, rsp_z, rsp_o, rsp_err
   );

endinterface

// File: rtl/ula_lo.sv
// Logic-only ALU: single-step shifts plus a 16-function bitwise unit.
module ula_lo
   import ula_pkg::*;
#(
   parameter int BITS = 8
) (
   input  logic [BITS-1:0] a,
   input  logic [BITS-1:0] b,
   input  logic [4:0]      op,
   output logic [BITS-1:0] resu
);

   logic [3:0] lop;

   assign lop = op[3:0];

   // Logic ops: op[3:0] is a truth table indexed by {~b, ~a} per bit
   always_comb begin
      resu = '0;
      unique case (1'b1)
         op == OP_SHL: resu = {a[BITS-2:0], 1'b0};
         op == OP_SAR: resu = {a[BITS-1], a[BITS-1:1]};
         op[4]: begin
            for (int i = 0; i < BITS; i++) begin
               resu[i] = lop[{~b[i], ~a[i]}];
            end
         end
         default: resu = '0;
      endcase
   end

endmodule

// File: rtl/ula_lo_ctrl.sv
// Multi-cycle sequencer around ULA_LO: iterates shifts, returns
// result and flags over a valid/ready response channel.
module ula_lo_ctrl
   import ula_pkg::*;
#(
   parameter int BITS = 8
) (
   input logic          clk,
   input logic          rst_n,
   ula_lo_ctrl_if.slave bus
);

   localparam int CW = $clog2(BITS + 1);

   state_t          state;
   logic [BITS-1:0] wa;
   logic [BITS-1:0] wb;
   logic [4:0]      wop;
   logic [CW-1:0]   wcnt;
   logic            wc;

   logic            req_ready;
   logic            rsp_valid;
   logic [BITS-1:0] rsp_resu;
   logic            rsp_c;
   logic            rsp_s;
   logic            rsp_z;
   logic            rsp_err;

   logic [BITS-1:0] alu_resu;
   logic            shift;
   logic            step;
   logic            last;
   logic            step_c;

   logic [BITS-1:0] fin_resu;
   logic            fin_c;
   logic            fin_s;
   logic            fin_z;
   logic            fin_err;
   logic            std_logic_op;

   ula_lo #(
      .BITS(BITS)
   ) u_alu (
      .a   (wa),
      .b   (wb),
      .op  (wop),
      .resu(alu_resu)
   );

   assign shift  = is_shift(wop);
   assign step   = shift && (wcnt != '0);
   assign last   = !shift || (wcnt <= CW'(1));
   assign step_c = (wop == OP_SHL) ? wa[BITS-1] : wa[0];

   assign std_logic_op = wop[4] && (wop != OP_ZERO)
                      && (wop != OP_PASSB) && (wop != OP_ONE);

   always_comb begin
      fin_resu = rsp_resu;
      fin_c    = rsp_c;
      fin_s    = rsp_s;
      fin_z    = rsp_z;
      fin_err  = 1'b0;
      unique case (1'b1)
         shift: begin
            fin_resu = step ? alu_resu : wa;
            fin_c    = step ? step_c : wc;
            fin_s    = fin_resu[BITS-1];
            fin_z    = (fin_resu == '0);
         end
         std_logic_op: begin
            fin_resu = alu_resu;
            fin_c    = 1'b0;
            fin_s    = alu_resu[BITS-1];
            fin_z    = (alu_resu == '0);
         end
         wop == OP_ZERO: begin
            fin_resu = alu_resu;
            fin_c    = 1'b0;
            fin_z    = (alu_resu == '0);
         end
         (wop == OP_PASSB) || (wop == OP_ONE): begin
            fin_resu = alu_resu;
            fin_c    = 1'b0;
         end
         default: begin
            fin_resu = '0;
            fin_err  = 1'b1;
         end
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state     <= IDLE;
         wa        <= '0;
         wb        <= '0;
         wop       <= '0;
         wcnt      <= '0;
         wc        <= 1'b0;
         req_ready <= 1'b1;
         rsp_valid <= 1'b0;
         rsp_resu  <= '0;
         rsp_c     <= 1'b0;
         rsp_s     <= 1'b0;
         rsp_z     <= 1'b0;
         rsp_err   <= 1'b0;
      end else begin
         unique case (state)
            IDLE: begin
               if (bus.req_valid) begin
                  wa        <= bus.req_a;
                  wb        <= bus.req_b;
                  wop       <= bus.req_op;
                  wcnt      <= (bus.req_cnt > CW'(BITS)) ?
                               CW'(BITS) : bus.req_cnt;
                  wc        <= 1'b0;
                  rsp_err   <= 1'b0;
                  req_ready <= 1'b0;
                  state     <= RUN;
               end
            end
            RUN: begin
               if (bus.clr) begin
                  req_ready <= 1'b1;
                  state     <= IDLE;
               end else begin
                  if (step) begin
                     wa   <= alu_resu;
                     wc   <= step_c;
                     wcnt <= wcnt - CW'(1);
                  end
                  if (last) begin
                     rsp_resu  <= fin_resu;
                     rsp_c     <= fin_c;
                     rsp_s     <= fin_s;
                     rsp_z     <= fin_z;
                     rsp_err   <= fin_err;
                     rsp_valid <= 1'b1;
                     state     <= DONE;
                  end
               end
            end
            DONE: begin
               if (bus.rsp_ready) begin
                  rsp_valid <= 1'b0;
                  req_ready <= 1'b1;
                  state     <= IDLE;
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

   assign bus.req_ready = req_ready;
   assign bus.rsp_valid = rsp_valid;
   assign bus.rsp_resu  = rsp_resu;
   assign bus.rsp_c     = rsp_c;
   assign bus.rsp_s     = rsp_s;
   assign bus.rsp_z     = rsp_z;
   assign bus.rsp_o     = 1'b0;
   assign bus.rsp_err   = rsp_err;

endmodule

// File: tb/tb_ula_lo_ctrl.sv
// Bench for ula_lo_ctrl: directed table, corner sequences, random vs model.
module tb_ula_lo_ctrl;

   logic clk = 1'b0;
   logic rst_n = 1'b0;
   always #5 clk = ~clk;

   ula_lo_ctrl_if #(.BITS(8)) bus ();

   ula_lo_ctrl #(.BITS(8)) dut (
      .clk  (clk),
      .rst_n(rst_n),
      .bus  (bus)
   );

   int checks = 0;
   int errors = 0;

   logic [7:0] m_resu;
   logic       m_c, m_s, m_z, m_err;

   typedef struct {
      logic [7:0] a;
      logic [7:0] b;
      logic [4:0] op;
      logic [3:0] cnt;
      logic [7:0] resu;
      logic       c;
      logic       s;
      logic       z;
      logic       err;
   } vec_t;

   vec_t vt[14];

   task automatic chk(input string name, input logic [31:0] got,
                      input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", name, got, exp);
      end
   endtask

   function automatic int exp_lat(input logic [4:0] op,
                                  input logic [3:0] cnt);
      int n;
      if (op == 5'b01000 || op == 5'b01001) begin
         n = (cnt > 8) ? 8 : int'(cnt);
         return (n == 0) ? 1 : n;
      end
      return 1;
   endfunction

   // Reference: shifts as repeated arithmetic, logic ops as minterm sums
   task automatic model(input logic [7:0] a, input logic [7:0] b,
                        input logic [4:0] op, input logic [3:0] cnt);
      int n;
      logic [7:0] r;
      logic c;
      if (op == 5'b01000 || op == 5'b01001) begin
         n = (cnt > 8) ? 8 : int'(cnt);
         r = a;
         c = 1'b0;
         for (int i = 0; i < n; i++) begin
            if (op == 5'b01000) begin
               c = (r >= 8'h80);
               r = 8'((r * 2) % 256);
            end else begin
               c = (r % 2 == 1);
               r = (r / 2) + (r & 8'h80);
            end
         end
         m_resu = r; m_c = c; m_z = (r == 0); m_s = (r >= 8'h80);
         m_err = 1'b0;
      end else if (op[4]) begin
         r = (op[0] ? (a & b) : 8'h00) | (op[1] ? (~a & b) : 8'h00)
           | (op[2] ? (a & ~b) : 8'h00) | (op[3] ? (~a & ~b) : 8'h00);
         m_resu = r; m_c = 1'b0; m_err = 1'b0;
         if (op != 5'b10011 && op != 5'b11111) begin
            m_z = (r == 0);
            if (op != 5'b10000) m_s = (r >= 8'h80);
         end
      end else begin
         m_resu = 8'h00;
         m_err = 1'b1;
      end
   endtask

   task automatic issue(input logic [7:0] a, input logic [7:0] b,
                        input logic [4:0] op, input logic [3:0] cnt);
      int t;
      @(negedge clk);
      bus.req_a = a; bus.req_b = b; bus.req_op = op; bus.req_cnt = cnt;
      bus.req_valid = 1'b1;
      t = 0;
      while (!bus.req_ready && t < 50) begin
         @(negedge clk);
         t++;
      end
      if (!bus.req_ready) chk("accept_timeout", 0, 1);
      @(posedge clk);
      #1 bus.req_valid = 1'b0;
   endtask

   task automatic wait_rsp(output int lat);
      lat = 0;
      while (!bus.rsp_valid && lat < 40) begin
         @(posedge clk);
         #1;
         lat++;
      end
      if (!bus.rsp_valid) chk("rsp_timeout", 0, 1);
   endtask

   task automatic ack();
      @(negedge clk);
      bus.rsp_ready = 1'b1;
      @(posedge clk);
      #1 bus.rsp_ready = 1'b0;
      chk("ack_valid_low", bus.rsp_valid, 0);
      chk("ack_ready_high", bus.req_ready, 1);
   endtask

   task automatic run_model_chk(input string tag, input logic [7:0] a,
                                input logic [7:0] b, input logic [4:0] op,
                                input logic [3:0] cnt);
      int lat;
      issue(a, b, op, cnt);
      wait_rsp(lat);
      model(a, b, op, cnt);
      chk({tag, "_lat"}, lat, exp_lat(op, cnt));
      chk({tag, "_resu"}, bus.rsp_resu, m_resu);
      chk({tag, "_flags"}, {bus.rsp_c, bus.rsp_s, bus.rsp_z, bus.rsp_err},
          {m_c, m_s, m_z, m_err});
      chk({tag, "_o"}, bus.rsp_o, 0);
      ack();
   endtask

   task automatic chk_zero_out(input string tag);
      chk({tag, "_resu"}, bus.rsp_resu, 0);
      chk({tag, "_flags"},
          {bus.rsp_c, bus.rsp_s, bus.rsp_z, bus.rsp_o, bus.rsp_err}, 0);
      chk({tag, "_valid"}, bus.rsp_valid, 0);
   endtask

   initial begin
      int lat;
      logic [7:0] ra, rb;
      logic [4:0] rop;
      logic [3:0] rcnt;

      vt[0]  = '{8'h81, 8'h00, 5'b01000, 4'd3,  8'h08, 0, 0, 0, 0};
      vt[1]  = '{8'h81, 8'h00, 5'b01000, 4'd1,  8'h02, 1, 0, 0, 0};
      vt[2]  = '{8'h90, 8'h00, 5'b01001, 4'd2,  8'hE4, 0, 1, 0, 0};
      vt[3]  = '{8'h90, 8'h00, 5'b01001, 4'd12, 8'hFF, 1, 1, 0, 0};
      vt[4]  = '{8'hF0, 8'h0F, 5'b10001, 4'd0,  8'h00, 0, 0, 1, 0};
      vt[5]  = '{8'h00, 8'h80, 5'b10011, 4'd0,  8'h80, 0, 0, 1, 0};
      vt[6]  = '{8'h80, 8'h00, 5'b01000, 4'd1,  8'h00, 1, 0, 1, 0};
      vt[7]  = '{8'h12, 8'h34, 5'b00011, 4'd0,  8'h00, 1, 0, 1, 1};
      vt[8]  = '{8'h55, 8'h00, 5'b11111, 4'd0,  8'hFF, 0, 0, 1, 0};
      vt[9]  = '{8'h40, 8'h00, 5'b01000, 4'd1,  8'h80, 0, 1, 0, 0};
      vt[10] = '{8'hC3, 8'h00, 5'b10000, 4'd0,  8'h00, 0, 1, 1, 0};
      vt[11] = '{8'hA5, 8'h00, 5'b10101, 4'd0,  8'hA5, 0, 1, 0, 0};
      vt[12] = '{8'h3C, 8'h00, 5'b01000, 4'd0,  8'h3C, 0, 0, 0, 0};
      vt[13] = '{8'h5A, 8'h5A, 5'b10110, 4'd0,  8'h00, 0, 0, 1, 0};

      bus.req_valid = 1'b0; bus.req_a = '0; bus.req_b = '0;
      bus.req_op = '0; bus.req_cnt = '0; bus.clr = 1'b0;
      bus.rsp_ready = 1'b0;
      m_resu = '0; m_c = 0; m_s = 0; m_z = 0; m_err = 0;

      #12;
      chk_zero_out("reset");
      @(negedge clk);
      rst_n = 1'b1;
      @(negedge clk);
      chk("reset_ready", bus.req_ready, 1);

      for (int i = 0; i < 14; i++) begin
         issue(vt[i].a, vt[i].b, vt[i].op, vt[i].cnt);
         wait_rsp(lat);
         model(vt[i].a, vt[i].b, vt[i].op, vt[i].cnt);
         chk($sformatf("vec%0d_lat", i), lat, exp_lat(vt[i].op, vt[i].cnt));
         chk($sformatf("vec%0d_resu", i), bus.rsp_resu, vt[i].resu);
         chk($sformatf("vec%0d_flags", i),
             {bus.rsp_c, bus.rsp_s, bus.rsp_z, bus.rsp_err},
             {vt[i].c, vt[i].s, vt[i].z, vt[i].err});
         ack();
      end

      // CLR in the 3rd RUN cycle of a 5-step shift
      run_model_chk("pre_clr", 8'h81, 8'h00, 5'b01000, 4'd1);
      issue(8'h01, 8'h00, 5'b01000, 4'd5);
      @(posedge clk);
      @(posedge clk);
      @(negedge clk);
      bus.clr = 1'b1;
      @(posedge clk);
      #1 bus.clr = 1'b0;
      chk("clr_ready", bus.req_ready, 1);
      chk("clr_valid", bus.rsp_valid, 0);
      chk("clr_resu_kept", bus.rsp_resu, m_resu);
      chk("clr_flags_kept", {bus.rsp_c, bus.rsp_s, bus.rsp_z, bus.rsp_err},
          {m_c, m_s, m_z, m_err});
      repeat (6) @(posedge clk);
      #1 chk("clr_no_rsp", bus.rsp_valid, 0);

      // Reset pulse mid-RUN
      issue(8'h01, 8'h00, 5'b01000, 4'd5);
      @(posedge clk);
      @(negedge clk);
      rst_n = 1'b0;
      #1 chk_zero_out("rst_mid");
      @(negedge clk);
      rst_n = 1'b1;
      m_resu = '0; m_c = 0; m_s = 0; m_z = 0; m_err = 0;
      chk("rst_mid_ready", bus.req_ready, 1);
      repeat (6) @(posedge clk);
      #1 chk_zero_out("rst_mid_after");

      // Hold response for 10 cycles while a new request waits
      issue(8'hF0, 8'h0F, 5'b10001, 4'd0);
      wait_rsp(lat);
      model(8'hF0, 8'h0F, 5'b10001, 4'd0);
      @(negedge clk);
      bus.req_a = 8'hFF; bus.req_b = 8'hFF; bus.req_op = 5'b11111;
      bus.req_valid = 1'b1;
      for (int i = 0; i < 10; i++) begin
         @(posedge clk);
         #1;
         chk("hold_frozen",
             {bus.rsp_valid, bus.req_ready, bus.rsp_resu, bus.rsp_z},
             {1'b1, 1'b0, m_resu, m_z});
      end
      @(negedge clk);
      bus.req_valid = 1'b0;
      bus.rsp_ready = 1'b1;
      @(posedge clk);
      #1 bus.rsp_ready = 1'b0;
      chk("hold_release", {bus.rsp_valid, bus.req_ready}, 2'b01);
      repeat (4) @(posedge clk);
      #1 chk("hold_req_ignored", bus.rsp_valid, 0);

      // Randomised traffic against the reference model
      for (int i = 0; i < 150; i++) begin
         ra = 8'($urandom);
         rb = 8'($urandom);
         rcnt = 4'($urandom_range(0, 15));
         case ($urandom_range(0, 3))
            0: rop = 5'b01000;
            1: rop = 5'b01001;
            default: rop = 5'($urandom);
         endcase
         run_model_chk("rand", ra, rb, rop, rcnt);
      end

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
